// File: rtl/interrupt_ccr_controller.sv
// Interrupt entry/exit sequencer and condition-code register owner.
// Captures rising edges of intReq, drains the pipe, freezes the CCR,
// pushes the resume PC as two stack words (high word first), then
// redirects fetch to the interrupt vector. RTI restores the frozen CCR.
module interrupt_ccr_controller #(
    parameter int unsigned         PC_WIDTH    = 32,
    parameter int unsigned         DATA_WIDTH  = 16,
    parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  intReq,
    input  logic                  pipeEmpty,
    input  logic                  flagWrite,
    input  logic                  aluZf,
    input  logic                  aluCf,
    input  logic                  aluOf,
    input  logic                  aluNf,
    input  logic                  rtiDone,
    input  logic [PC_WIDTH-1:0]   pcIn,
    input  logic                  pushReady,
    output logic [3:0]            ccr,
    output logic [3:0]            freezedCCR,
    output logic                  stall,
    output logic                  pushValid,
    output logic [DATA_WIDTH-1:0] pushData,
    output logic                  pcLoad,
    output logic [PC_WIDTH-1:0]   pcLoadValue,
    output logic                  intAck,
    output logic                  inIsr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FREEZE,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_VECTOR
    } state_e;

    state_e              state_q, state_d;
    logic                int_req_q, int_req_d;
    logic                pending_q, pending_d;
    logic                in_isr_q, in_isr_d;
    logic [3:0]          ccr_q, ccr_d;
    logic [3:0]          freezed_ccr_q, freezed_ccr_d;
    logic [PC_WIDTH-1:0] pc_latch_q, pc_latch_d;

    logic int_rise;
    logic in_freeze;

    assign int_rise  = intReq & ~int_req_q;
    assign in_freeze = (state_q == ST_FREEZE);

    assign ccr        = ccr_q;
    assign freezedCCR = freezed_ccr_q;
    assign inIsr      = in_isr_q;

    // Edge capture, pending flag, CCR update priority and ISR bookkeeping
    always_comb begin
        int_req_d     = intReq;
        pending_d     = pending_q;
        in_isr_d      = in_isr_q;
        ccr_d         = ccr_q;
        freezed_ccr_d = freezed_ccr_q;
        pc_latch_d    = pc_latch_q;

        // Edges arriving while already pending merge into the same request;
        // the FREEZE cycle consumes it.
        if (in_freeze) begin
            pending_d = 1'b0;
        end else if (int_rise) begin
            pending_d = 1'b1;
        end

        // RTI restore beats a same-cycle flag commit; RTI outside an ISR is ignored.
        if (rtiDone && in_isr_q) begin
            ccr_d    = freezed_ccr_q;
            in_isr_d = 1'b0;
        end else if (flagWrite) begin
            ccr_d = {aluNf, aluOf, aluCf, aluZf};
        end

        // Snapshot taken from ccr_d so a flag commit in the FREEZE cycle is kept.
        if (in_freeze) begin
            freezed_ccr_d = ccr_d;
            pc_latch_d    = pcIn;
            in_isr_d      = 1'b1;
        end
    end

    // Next-state and Moore outputs of the entry sequencer
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        pushValid   = 1'b0;
        pushData    = '0;
        pcLoad      = 1'b0;
        pcLoadValue = '0;
        intAck      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q && !in_isr_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stall = 1'b1;
                if (pipeEmpty) begin
                    state_d = ST_FREEZE;
                end
            end
            ST_FREEZE: begin
                stall   = 1'b1;
                state_d = ST_PUSH_HI;
            end
            // Fetch stays frozen while the resume PC is being pushed.
            ST_PUSH_HI: begin
                stall     = 1'b1;
                pushValid = 1'b1;
                pushData  = pc_latch_q[DATA_WIDTH +: DATA_WIDTH];
                if (pushReady) begin
                    state_d = ST_PUSH_LO;
                end
            end
            ST_PUSH_LO: begin
                stall     = 1'b1;
                pushValid = 1'b1;
                pushData  = pc_latch_q[0 +: DATA_WIDTH];
                if (pushReady) begin
                    state_d = ST_VECTOR;
                end
            end
            ST_VECTOR: begin
                stall       = 1'b1;
                pcLoad      = 1'b1;
                intAck      = 1'b1;
                pcLoadValue = VECTOR_ADDR;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            int_req_q     <= 1'b0;
            pending_q     <= 1'b0;
            in_isr_q      <= 1'b0;
            ccr_q         <= '0;
            freezed_ccr_q <= '0;
            pc_latch_q    <= '0;
        end else begin
            state_q       <= state_d;
            int_req_q     <= int_req_d;
            pending_q     <= pending_d;
            in_isr_q      <= in_isr_d;
            ccr_q         <= ccr_d;
            freezed_ccr_q <= freezed_ccr_d;
            pc_latch_q    <= pc_latch_d;
        end
    end

endmodule

// File: tb/tb_interrupt_ccr_controller.sv
// Self-checking bench for interrupt_ccr_controller. Stack words and vector
// redirects are predicted into queues when an interrupt is raised and are
// consumed by a negedge monitor as the DUT produces them.
module tb_interrupt_ccr_controller;

    localparam logic [31:0] VEC = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        intReq = 1'b0;
    logic        pipeEmpty = 1'b0;
    logic        flagWrite = 1'b0;
    logic        aluZf = 1'b0;
    logic        aluCf = 1'b0;
    logic        aluOf = 1'b0;
    logic        aluNf = 1'b0;
    logic        rtiDone = 1'b0;
    logic [31:0] pcIn = '0;
    logic        pushReady = 1'b0;
    logic [3:0]  ccr;
    logic [3:0]  freezedCCR;
    logic        stall;
    logic        pushValid;
    logic [15:0] pushData;
    logic        pcLoad;
    logic [31:0] pcLoadValue;
    logic        intAck;
    logic        inIsr;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] push_q[$];
    logic [31:0] vec_q[$];

    interrupt_ccr_controller #(
        .PC_WIDTH   (32),
        .DATA_WIDTH (16),
        .VECTOR_ADDR(VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .intReq     (intReq),
        .pipeEmpty  (pipeEmpty),
        .flagWrite  (flagWrite),
        .aluZf      (aluZf),
        .aluCf      (aluCf),
        .aluOf      (aluOf),
        .aluNf      (aluNf),
        .rtiDone    (rtiDone),
        .pcIn       (pcIn),
        .pushReady  (pushReady),
        .ccr        (ccr),
        .freezedCCR (freezedCCR),
        .stall      (stall),
        .pushValid  (pushValid),
        .pushData   (pushData),
        .pcLoad     (pcLoad),
        .pcLoadValue(pcLoadValue),
        .intAck     (intAck),
        .inIsr      (inIsr)
    );

    always #5 clk = ~clk;

    // Scoreboard side: consume predicted stack words and vector redirects.
    always @(negedge clk) begin : monitor
        logic [15:0] exp_w;
        logic [31:0] exp_v;
        if (!rst) begin
            if (pushValid && pushReady) begin
                n_cmp++;
                if (push_q.size() == 0) begin
                    n_err++;
                    $display("FAIL push_unexpected got=%h expected=none", pushData);
                end else begin
                    exp_w = push_q.pop_front();
                    if (pushData !== exp_w) begin
                        n_err++;
                        $display("FAIL push_word got=%h expected=%h", pushData, exp_w);
                    end
                end
            end
            if (pcLoad) begin
                n_cmp++;
                if (vec_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pcload_unexpected got=%h expected=none", pcLoadValue);
                end else begin
                    exp_v = vec_q.pop_front();
                    if (pcLoadValue !== exp_v || intAck !== 1'b1) begin
                        n_err++;
                        $display("FAIL vector got=%h ack=%b expected=%h ack=1", pcLoadValue, intAck, exp_v);
                    end
                end
            end else begin
                n_cmp++;
                if (intAck !== 1'b0 || pcLoadValue !== 32'h0) begin
                    n_err++;
                    $display("FAIL idle_vector got ack=%b val=%h expected ack=0 val=0", intAck, pcLoadValue);
                end
            end
        end
    end

    // RTI may only be presented while the sequencer is idle (stall low).
    always @(posedge clk) begin
        if (!rst && rtiDone) begin
            n_cmp++;
            assert (stall == 1'b0) else $error("rtiDone while sequencer busy");
            if (stall !== 1'b0) begin
                n_err++;
                $display("FAIL rti_when_busy got stall=%b expected=0", stall);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] nocz);
        aluNf = nocz[3];
        aluOf = nocz[2];
        aluCf = nocz[1];
        aluZf = nocz[0];
    endtask

    // Produce one intReq rising edge; returns in the first cycle with pending set.
    task automatic raise_int(input logic [31:0] pc, input bit exp_hi, input bit exp_rest);
        logic [15:0] hi;
        logic [15:0] lo;
        hi = pc[31:16];
        lo = pc[15:0];
        pcIn = pc;
        intReq = 1'b0;
        step();
        intReq = 1'b1;
        if (exp_hi) push_q.push_back(hi);
        if (exp_rest) begin
            push_q.push_back(lo);
            vec_q.push_back(VEC);
        end
        step();
        intReq = 1'b0;
    endtask

    task automatic exit_isr();
        rtiDone = 1'b1;
        step();
        rtiDone = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_cmp++;
        if ({ccr, freezedCCR, stall, pushValid, pushData, pcLoad, pcLoadValue, intAck, inIsr} !== '0) begin
            n_err++;
            $display("FAIL reset_state got ccr=%b frz=%b stall=%b pv=%b pd=%h pl=%b plv=%h ack=%b isr=%b expected all 0",
                     ccr, freezedCCR, stall, pushValid, pushData, pcLoad, pcLoadValue, intAck, inIsr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_entry();
        logic exp_pl;
        set_flags(4'b1010);
        flagWrite = 1'b1;
        step();
        flagWrite = 1'b0;
        set_flags(4'b0000);
        n_cmp++;
        if (ccr !== 4'b1010) begin
            n_err++;
            $display("FAIL entry_ccr got=%b expected=1010", ccr);
        end
        pipeEmpty = 1'b1;
        pushReady = 1'b1;
        raise_int(32'h1234_5678, 1'b1, 1'b1);
        n_cmp++;
        if (stall !== 1'b0) begin
            n_err++;
            $display("FAIL entry_pending_idle got stall=%b expected=0", stall);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_pl = (i == 5);
            n_cmp++;
            if (pcLoad !== exp_pl) begin
                n_err++;
                $display("FAIL entry_latency cycle %0d got pcLoad=%b expected=%b", i, pcLoad, exp_pl);
            end
            if (i == 3) begin
                n_cmp++;
                if (freezedCCR !== 4'b1010 || inIsr !== 1'b1) begin
                    n_err++;
                    $display("FAIL entry_freeze got frz=%b isr=%b expected frz=1010 isr=1", freezedCCR, inIsr);
                end
            end
        end
        step();
        n_cmp++;
        if ({stall, pcLoad, inIsr} !== 3'b001) begin
            n_err++;
            $display("FAIL entry_done got stall/pl/isr=%b expected=001", {stall, pcLoad, inIsr});
        end
    endtask

    task automatic test_rti_restore();
        set_flags(4'b0001);
        flagWrite = 1'b1;
        step();
        n_cmp++;
        if (ccr !== 4'b0001 || inIsr !== 1'b1) begin
            n_err++;
            $display("FAIL isr_flagwrite got ccr=%b isr=%b expected ccr=0001 isr=1", ccr, inIsr);
        end
        set_flags(4'b0111);
        exit_isr();
        flagWrite = 1'b0;
        n_cmp++;
        if (ccr !== 4'b1010 || inIsr !== 1'b0 || freezedCCR !== 4'b1010) begin
            n_err++;
            $display("FAIL rti_restore got ccr=%b isr=%b frz=%b expected ccr=1010 isr=0 frz=1010", ccr, inIsr, freezedCCR);
        end
    endtask

    task automatic test_nesting();
        set_flags(4'b0101);
        flagWrite = 1'b1;
        step();
        flagWrite = 1'b0;
        exit_isr();
        n_cmp++;
        if (ccr !== 4'b0101 || inIsr !== 1'b0) begin
            n_err++;
            $display("FAIL rti_outside_isr got ccr=%b isr=%b expected ccr=0101 isr=0", ccr, inIsr);
        end
        set_flags(4'b0011);
        flagWrite = 1'b1;
        exit_isr();
        flagWrite = 1'b0;
        n_cmp++;
        if (ccr !== 4'b0011) begin
            n_err++;
            $display("FAIL rti_outside_isr_flagwrite got ccr=%b expected=0011", ccr);
        end
        pipeEmpty = 1'b1;
        pushReady = 1'b1;
        raise_int(32'hA5A5_5A5A, 1'b1, 1'b1);
        repeat (5) step();
        n_cmp++;
        if (pcLoad !== 1'b1 || freezedCCR !== 4'b0011) begin
            n_err++;
            $display("FAIL nest_first_entry got pl=%b frz=%b expected pl=1 frz=0011", pcLoad, freezedCCR);
        end
        step();
        raise_int(32'h1357_9BDF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (stall !== 1'b0 || pushValid !== 1'b0 || inIsr !== 1'b1) begin
                n_err++;
                $display("FAIL nest_masked got stall=%b pv=%b isr=%b expected 0 0 1", stall, pushValid, inIsr);
            end
        end
        exit_isr();
        n_cmp++;
        if (inIsr !== 1'b0 || stall !== 1'b0 || ccr !== 4'b0011) begin
            n_err++;
            $display("FAIL nest_rti got isr=%b stall=%b ccr=%b expected 0 0 0011", inIsr, stall, ccr);
        end
        step();
        n_cmp++;
        if (stall !== 1'b1 || pushValid !== 1'b0) begin
            n_err++;
            $display("FAIL nest_drain_start got stall=%b pv=%b expected 1 0", stall, pushValid);
        end
        repeat (3) step();
        step();
        n_cmp++;
        if (pcLoad !== 1'b1) begin
            n_err++;
            $display("FAIL nest_second_vector got pl=%b expected=1", pcLoad);
        end
        step();
        exit_isr();
    endtask

    task automatic test_push_backpressure();
        pipeEmpty = 1'b1;
        pushReady = 1'b0;
        raise_int(32'hDEAD_BEEF, 1'b1, 1'b1);
        repeat (3) step();
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (pushValid !== 1'b1 || pushData !== 16'hDEAD) begin
                n_err++;
                $display("FAIL push_hi_hold cycle %0d got pv=%b pd=%h expected pv=1 pd=dead", k, pushValid, pushData);
            end
            if (k == 3) begin
                n_cmp++;
                if (ccr !== 4'b1111 || freezedCCR !== 4'b0011) begin
                    n_err++;
                    $display("FAIL push_flagwrite got ccr=%b frz=%b expected ccr=1111 frz=0011", ccr, freezedCCR);
                end
            end
            pushReady = (k == 4);
            flagWrite = (k == 2);
            set_flags(4'b1111);
            step();
        end
        n_cmp++;
        if (pushValid !== 1'b1 || pushData !== 16'hBEEF) begin
            n_err++;
            $display("FAIL push_lo got pv=%b pd=%h expected pv=1 pd=beef", pushValid, pushData);
        end
        step();
        n_cmp++;
        if (pcLoad !== 1'b1 || pushValid !== 1'b0 || pushData !== 16'h0) begin
            n_err++;
            $display("FAIL push_vector got pl=%b pv=%b pd=%h expected 1 0 0", pcLoad, pushValid, pushData);
        end
        step();
        exit_isr();
        n_cmp++;
        if (ccr !== 4'b0011 || inIsr !== 1'b0) begin
            n_err++;
            $display("FAIL push_rti got ccr=%b isr=%b expected 0011 0", ccr, inIsr);
        end
    endtask

    task automatic test_drain();
        pushReady = 1'b1;
        pipeEmpty = 1'b0;
        raise_int(32'h0BAD_F00D, 1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            n_cmp++;
            if (stall !== 1'b1 || pushValid !== 1'b0 || inIsr !== 1'b0) begin
                n_err++;
                $display("FAIL drain_hold cycle %0d got stall=%b pv=%b isr=%b expected 1 0 0", k, stall, pushValid, inIsr);
            end
        end
        pipeEmpty = 1'b1;
        step();
        n_cmp++;
        if (stall !== 1'b1 || pushValid !== 1'b0 || inIsr !== 1'b0) begin
            n_err++;
            $display("FAIL drain_freeze got stall=%b pv=%b isr=%b expected 1 0 0", stall, pushValid, inIsr);
        end
        step();
        n_cmp++;
        if (pushValid !== 1'b1 || inIsr !== 1'b1 || pushData !== 16'h0BAD) begin
            n_err++;
            $display("FAIL drain_push got pv=%b isr=%b pd=%h expected 1 1 0bad", pushValid, inIsr, pushData);
        end
        step();
        step();
        n_cmp++;
        if (pcLoad !== 1'b1) begin
            n_err++;
            $display("FAIL drain_vector got pl=%b expected=1", pcLoad);
        end
        step();
        exit_isr();
    endtask

    task automatic test_reset_mid_push();
        pipeEmpty = 1'b1;
        pushReady = 1'b1;
        raise_int(32'hCAFE_F00D, 1'b1, 1'b0);
        repeat (4) step();
        pushReady = 1'b0;
        n_cmp++;
        if (pushValid !== 1'b1 || pushData !== 16'hF00D) begin
            n_err++;
            $display("FAIL mid_push_lo got pv=%b pd=%h expected pv=1 pd=f00d", pushValid, pushData);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ccr, freezedCCR, stall, pushValid, pushData, pcLoad, pcLoadValue, intAck, inIsr} !== '0) begin
            n_err++;
            $display("FAIL async_reset got ccr=%b frz=%b stall=%b pv=%b pd=%h pl=%b plv=%h ack=%b isr=%b expected all 0",
                     ccr, freezedCCR, stall, pushValid, pushData, pcLoad, pcLoadValue, intAck, inIsr);
        end
        step();
        rst = 1'b0;
        pushReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (stall !== 1'b0 || pcLoad !== 1'b0 || pushValid !== 1'b0 || inIsr !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_quiet cycle %0d got stall=%b pl=%b pv=%b isr=%b expected 0 0 0 0",
                         i, stall, pcLoad, pushValid, inIsr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_rti_restore();
        test_nesting();
        test_push_backpressure();
        test_drain();
        test_reset_mid_push();
        n_cmp++;
        if (push_q.size() != 0 || vec_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got push_left=%0d vec_left=%0d expected 0 0", push_q.size(), vec_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
